// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file
// writeback arbiter and its round-robin sub-arbiter.
package regfile_pkg;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  typedef enum logic {
    PRI_WB0 = 1'b0,
    PRI_WB1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter. The priority pointer only
// moves after a grant made while both inputs were requesting.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_ptr_e ptr_q;
  rr_ptr_e ptr_d;

  // grant selection and pointer update on contention
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    case (req)
      2'b11: begin
        gnt   = (ptr_q == PRI_WB1) ? 2'b10 : 2'b01;
        ptr_d = (ptr_q == PRI_WB1) ? PRI_WB0 : PRI_WB1;
      end
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // priority pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PRI_WB0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the
// ALU and load writeback paths, with a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int NREGS            = regfile_pkg::NREGS,
  parameter int AW               = regfile_pkg::AW,
  parameter int DW               = regfile_pkg::DW,
  parameter int CW               = regfile_pkg::CW,
  parameter bit ZERO_REG_DISCARD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb0_valid,
  input  logic [AW-1:0]    wb0_addr,
  input  logic [DW-1:0]    wb0_data,
  output logic             wb0_ready,
  input  logic             wb1_valid,
  input  logic [AW-1:0]    wb1_addr,
  input  logic [DW-1:0]    wb1_data,
  output logic             wb1_ready,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_ready,
  output logic             rf_write_en,
  output logic [15:0]      rf_write_address,
  output logic [DW-1:0]    rf_write_data,
  output logic [NREGS-1:0] pending_mask
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  regfile_pkg::wb_req_t req0;
  regfile_pkg::wb_req_t req1;
  regfile_pkg::wb_req_t win;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       hs;
  logic       drop;

  assign req0 = {wb0_addr, wb0_data};
  assign req1 = {wb1_addr, wb1_data};
  assign req  = {wb1_valid, wb0_valid};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];
  assign hs        = |gnt;
  assign win       = gnt[1] ? req1 : req0;
  assign drop      = ZERO_REG_DISCARD && (win.addr == '0);

  logic          we_q;
  logic          we_d;
  logic [AW-1:0] wa_q;
  logic [AW-1:0] wa_d;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] wd_d;

  // stage the winning write; r0 writes complete but never commit
  always_comb begin
    we_d = hs && !drop;
    wa_d = wa_q;
    wd_d = wd_q;
    if (we_d) begin
      wa_d = win.addr;
      wd_d = win.data;
    end
  end

  // registered write-port stage
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
    end
  end

  assign rf_write_en      = we_q;
  assign rf_write_address = 16'(wa_q);
  assign rf_write_data    = wd_q;

  logic [CW-1:0]    cnt_q [NREGS];
  logic [CW-1:0]    cnt_d [NREGS];
  logic [NREGS-1:0] inc_vec;
  logic [NREGS-1:0] dec_vec;
  logic             rsv_hit;
  logic             rsv_zero;
  logic             rsv_inc;

  assign rsv_hit   = we_q && (wa_q == rsv_addr);
  assign rsv_zero  = ZERO_REG_DISCARD && (rsv_addr == '0);
  assign rsv_ready = (cnt_q[rsv_addr] != CNT_MAX) || rsv_hit;
  assign rsv_inc   = rsv_valid && rsv_ready && !rsv_zero;

  // one-hot reserve/commit strobes; a commit never underflows
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (rsv_inc) begin
      inc_vec[rsv_addr] = 1'b1;
    end
    if (we_q && (cnt_q[wa_q] != '0)) begin
      dec_vec[wa_q] = 1'b1;
    end
  end

  // per-register counter update; reserve and commit cancel out
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i]
               + CW'(inc_vec[i])
               - CW'(dec_vec[i]);
    end
  end

  // scoreboard counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // pending mask from registered counts
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NREGS; i++) begin
      pending_mask[i] = (cnt_q[i] != '0);
    end
  end

`ifndef SYNTHESIS
  a_no_commit_unreserved : assert property (
    @(posedge clk) disable iff (rst)
    we_q |-> (cnt_q[wa_q] != '0)
  );
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plan plus randomized traffic, checked
// every cycle against a behavioural model of arbitration and scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb0_valid = 1'b0;
  logic [4:0]  wb0_addr = '0;
  logic [31:0] wb0_data = '0;
  logic        wb0_ready;
  logic        wb1_valid = 1'b0;
  logic [4:0]  wb1_addr = '0;
  logic [31:0] wb1_data = '0;
  logic        wb1_ready;
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic        rsv_ready;
  logic        rf_write_en;
  logic [15:0] rf_write_address;
  logic [31:0] rf_write_data;
  logic [31:0] pending_mask;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .wb0_valid        (wb0_valid),
    .wb0_addr         (wb0_addr),
    .wb0_data         (wb0_data),
    .wb0_ready        (wb0_ready),
    .wb1_valid        (wb1_valid),
    .wb1_addr         (wb1_addr),
    .wb1_data         (wb1_data),
    .wb1_ready        (wb1_ready),
    .rsv_valid        (rsv_valid),
    .rsv_addr         (rsv_addr),
    .rsv_ready        (rsv_ready),
    .rf_write_en      (rf_write_en),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .pending_mask     (pending_mask)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // behavioural model state
  int          m_cnt [32];
  bit          m_en   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_ptr  = 1'b0;

  function automatic bit m_g1();
    if (wb0_valid && wb1_valid) return m_ptr;
    return wb1_valid;
  endfunction

  function automatic bit m_rsv_ok();
    return (m_cnt[rsv_addr] < 3) || (m_en && m_addr == rsv_addr);
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (m_cnt[i] != 0);
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
  end

  // model advance at each rising edge
  always @(posedge clk) begin
    bit          g1;
    bit          hs;
    bit          ok;
    logic [4:0]  wa;
    logic [31:0] wd;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_en = 0; m_addr = '0; m_data = '0; m_ptr = 0;
    end else begin
      g1 = m_g1();
      hs = wb0_valid || wb1_valid;
      ok = rsv_valid && m_rsv_ok();
      wa = g1 ? wb1_addr : wb0_addr;
      wd = g1 ? wb1_data : wb0_data;
      if (m_en && m_cnt[m_addr] > 0) m_cnt[m_addr]--;
      if (ok && rsv_addr != 0) m_cnt[rsv_addr]++;
      m_en = hs && (wa != 0);
      if (m_en) begin
        m_addr = wa;
        m_data = wd;
      end
      if (wb0_valid && wb1_valid) m_ptr = !m_ptr;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    bit g1;
    if (!rst) begin
      g1 = m_g1();
      chk("wb0_ready", 32'(wb0_ready), 32'(wb0_valid && !g1));
      chk("wb1_ready", 32'(wb1_ready), 32'(g1));
      chk("rsv_ready", 32'(rsv_ready), 32'(m_rsv_ok()));
      chk("rf_write_en", 32'(rf_write_en), 32'(m_en));
      if (m_en) begin
        chk("rf_write_address", 32'(rf_write_address), 32'(m_addr));
        chk("rf_write_data", rf_write_data, m_data);
      end
      chk("pending_mask", pending_mask, m_mask());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reserve(input logic [4:0] a);
    rsv_valid = 1'b1;
    rsv_addr  = a;
    tick();
    rsv_valid = 1'b0;
  endtask

  int budget [32];
  bit h0, h1, ra;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_en", 32'(rf_write_en), 0);
    chk("rst_addr", 32'(rf_write_address), 0);
    chk("rst_data", rf_write_data, 0);
    chk("rst_mask", pending_mask, 0);

    // single ALU write to r5
    reserve(5'd5);
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    #2 chk("single_ready", 32'(wb0_ready), 1);
    tick();
    wb0_valid = 1'b0;
    chk("single_en", 32'(rf_write_en), 1);
    chk("single_addr", 32'(rf_write_address), 5);
    chk("single_data", rf_write_data, 32'hDEADBEEF);
    tick();
    chk("single_en_off", 32'(rf_write_en), 0);
    chk("single_mask5", 32'(pending_mask[5]), 0);

    // contention
    reserve(5'd1);
    reserve(5'd1);
    reserve(5'd2);
    wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h11;
    wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'h22;
    #2 chk("cont_g0a", 32'(wb0_ready), 1);
    chk("cont_g1a", 32'(wb1_ready), 0);
    tick();
    chk("cont_addr_a", 32'(rf_write_address), 1);
    #2 chk("cont_g1b", 32'(wb1_ready), 1);
    chk("cont_g0b", 32'(wb0_ready), 0);
    tick();
    chk("cont_addr_b", 32'(rf_write_address), 2);
    #2 chk("cont_g0c", 32'(wb0_ready), 1);
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    chk("cont_addr_c", 32'(rf_write_address), 1);
    chk("cont_en_c", 32'(rf_write_en), 1);
    tick();

    // scoreboard saturation on r7
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    #2 chk("r7_rsv1", 32'(rsv_ready), 1);
    tick();
    #2 chk("r7_rsv2", 32'(rsv_ready), 1);
    tick();
    chk("r7_mask", 32'(pending_mask[7]), 1);
    #2 chk("r7_rsv3", 32'(rsv_ready), 1);
    tick();
    #2 chk("r7_rsv4", 32'(rsv_ready), 0);
    tick();
    rsv_valid = 1'b0;
    wb1_valid = 1'b1; wb1_addr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      wb1_data = 32'h700 + 32'(i);
      tick();
    end
    wb1_valid = 1'b0;
    chk("r7_last_en", 32'(rf_write_en), 1);
    chk("r7_mask_hold", 32'(pending_mask[7]), 1);
    tick();
    chk("r7_mask_clr", 32'(pending_mask[7]), 0);

    // same-cycle reserve and commit on r9
    reserve(5'd9);
    wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h99;
    tick();
    wb0_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    #2 chk("r9_rsv", 32'(rsv_ready), 1);
    tick();
    rsv_valid = 1'b0;
    chk("r9_mask", 32'(pending_mask[9]), 1);
    tick();
    chk("r9_mask2", 32'(pending_mask[9]), 1);

    // r0 write is discarded
    wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFFFFFFFF;
    #2 chk("r0_ready", 32'(wb0_ready), 1);
    tick();
    wb0_valid = 1'b0;
    chk("r0_en", 32'(rf_write_en), 0);
    chk("r0_mask", pending_mask, 32'h0000_0200);

    // reset with a staged write and a reservation
    reserve(5'd3);
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h33;
    tick();
    wb0_valid = 1'b0;
    chk("pre_rst_en", 32'(rf_write_en), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_en", 32'(rf_write_en), 0);
    chk("mid_rst_mask", pending_mask, 0);
    reserve(5'd4);
    reserve(5'd6);
    wb0_valid = 1'b1; wb0_addr = 5'd4; wb0_data = 32'h44;
    wb1_valid = 1'b1; wb1_addr = 5'd6; wb1_data = 32'h66;
    #2 chk("post_rst_g0", 32'(wb0_ready), 1);
    chk("post_rst_g1", 32'(wb1_ready), 0);
    tick();
    wb0_valid = 1'b0;
    tick();
    wb1_valid = 1'b0;
    tick();
    tick();

    // randomized traffic
    for (int i = 0; i < 32; i++) budget[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [4:0] r;
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = 5'($urandom_range(0, 7));
      if (!wb0_valid && $urandom_range(0, 2) != 0) begin
        r = 5'($urandom_range(0, 7));
        if (r == 0 || budget[r] > 0) begin
          if (r != 0) budget[r]--;
          wb0_valid = 1'b1; wb0_addr = r; wb0_data = $urandom;
        end
      end
      if (!wb1_valid && $urandom_range(0, 2) != 0) begin
        r = 5'($urandom_range(0, 7));
        if (r == 0 || budget[r] > 0) begin
          if (r != 0) budget[r]--;
          wb1_valid = 1'b1; wb1_addr = r; wb1_data = $urandom;
        end
      end
      #2;
      h0 = wb0_valid && wb0_ready;
      h1 = wb1_valid && wb1_ready;
      ra = rsv_valid && rsv_ready;
      tick();
      if (h0) wb0_valid = 1'b0;
      if (h1) wb1_valid = 1'b0;
      if (ra && rsv_addr != 0) budget[rsv_addr]++;
    end

    // drain outstanding requests within a bounded window
    rsv_valid = 1'b0;
    for (int k = 0; k < 20 && (wb0_valid || wb1_valid); k++) begin
      #2;
      h0 = wb0_valid && wb0_ready;
      h1 = wb1_valid && wb1_ready;
      tick();
      if (h0) wb0_valid = 1'b0;
      if (h1) wb1_valid = 1'b0;
    end
    chk("drain_done", 32'(wb0_valid || wb1_valid), 0);
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
